// File: rtl/hbridge_pkg.sv
// Shared types and default widths for the hbridge PWM stage and its command front end.
package hbridge_pkg;

    localparam int unsigned DWID_DEF   = 8;
    localparam int unsigned FWID_DEF   = 8;
    localparam int unsigned DUTY_W_DEF = DWID_DEF + FWID_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        DRAIN = 2'd2,
        WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_period_tick.sv
// PWM period counter: counts 0..period-1 and flags the wrap; a new period is sampled at each wrap.
module pwm_period_tick #(
    parameter int unsigned DWID = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DWID-1:0] i_period,
    output logic            wrap_c,
    output logic            o_tick
);

    logic [DWID-1:0] cnt_q;
    logic [DWID-1:0] per_q;
    logic [DWID:0]   cnt_inc;

    // Period 0 or 1 wraps every cycle; the extra bit keeps cnt+1 from overflowing.
    assign cnt_inc = {1'b0, cnt_q} + (DWID+1)'(1);
    assign wrap_c  = (cnt_inc >= {1'b0, per_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '0;
            o_tick <= 1'b0;
        end else if (wrap_c) begin
            cnt_q  <= '0;
            per_q  <= i_period;
            o_tick <= 1'b1;
        end else begin
            cnt_q  <= cnt_inc[DWID-1:0];
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/hbridge_cmd_ramp.sv
// Command front end for the hbridge: slew-limited duty, sequenced direction reversal, tick-aligned updates.
// Optional command watchdog enabled by defining HBRIDGE_CMD_WDOG_EN.
module hbridge_cmd_ramp
    import hbridge_pkg::*;
#(
    parameter int unsigned DWID = DWID_DEF,
    parameter int unsigned FWID = FWID_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DWID-1:0]      i_period,
    input  logic [DWID+FWID-1:0] i_step,
    input  logic [DWID+FWID-1:0] i_max_duty,
    input  logic [DWID-1:0]      i_rev_wait,
    input  logic                 i_stop,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_dir,
    input  logic [DWID+FWID-1:0] i_cmd_duty,
    output logic                 o_enable,
    output logic                 o_pn,
    output logic [DWID-1:0]      o_hi_time,
    output logic [FWID-1:0]      o_hi_more_precision,
    output logic                 o_tick,
    output logic                 o_at_target,
    output logic                 o_busy
`ifdef HBRIDGE_CMD_WDOG_EN
    ,
    input  logic [DWID-1:0]      i_wdog_periods,
    output logic                 o_wdog_expired
`endif
);

    localparam int unsigned DW = DWID + FWID;

    state_t          state_q, state_nx;
    logic [DW-1:0]   duty_q, duty_nx;
    logic [DW-1:0]   tgt_q, tgt_nx;
    logic [DW-1:0]   pduty_q, pduty_nx;
    logic            pdir_q, pdir_nx;
    logic [DWID-1:0] dwell_q, dwell_nx;
    logic [DWID:0]   dwell_inc;
    logic            en_nx, pn_nx, at_nx, busy_nx;
    logic [DW-1:0]   cmd_cl;
    logic            acc;
    logic            tick_c;
`ifdef HBRIDGE_CMD_WDOG_EN
    logic [DWID-1:0] wd_cnt_q, wd_cnt_nx;
    logic [DWID:0]   wd_inc;
    logic            wd_exp_nx;
`endif

    pwm_period_tick #(.DWID(DWID)) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_period (i_period),
        .wrap_c   (tick_c),
        .o_tick   (o_tick)
    );

    // One slew step of d toward t; the add carries into an extra bit so it saturates at t.
    function automatic logic [DW-1:0] ramp_step(input logic [DW-1:0] d,
                                                input logic [DW-1:0] t,
                                                input logic [DW-1:0] s);
        logic [DW:0] sum;
        ramp_step = d;
        sum       = {1'b0, d} + {1'b0, s};
        if (s == '0)
            ramp_step = t;
        else if (d < t)
            ramp_step = (sum >= {1'b0, t}) ? t : sum[DW-1:0];
        else if (d > t)
            ramp_step = ((d - t) <= s) ? t : (d - s);
    endfunction

    assign o_cmd_ready         = !i_stop && (state_q == IDLE || state_q == RAMP);
    assign acc                 = i_cmd_valid && o_cmd_ready;
    assign o_hi_time           = duty_q[DW-1:FWID];
    assign o_hi_more_precision = duty_q[FWID-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            duty_q      <= '0;
            tgt_q       <= '0;
            pduty_q     <= '0;
            pdir_q      <= 1'b1;
            dwell_q     <= '0;
            o_enable    <= 1'b0;
            o_pn        <= 1'b1;
            o_at_target <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            state_q     <= state_nx;
            duty_q      <= duty_nx;
            tgt_q       <= tgt_nx;
            pduty_q     <= pduty_nx;
            pdir_q      <= pdir_nx;
            dwell_q     <= dwell_nx;
            o_enable    <= en_nx;
            o_pn        <= pn_nx;
            o_at_target <= at_nx;
            o_busy      <= busy_nx;
        end
    end

`ifdef HBRIDGE_CMD_WDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q       <= '0;
            o_wdog_expired <= 1'b0;
        end else begin
            wd_cnt_q       <= wd_cnt_nx;
            o_wdog_expired <= wd_exp_nx;
        end
    end
`endif

    // Command capture first, then the tick-time update acts on the post-command view.
    always_comb begin
        state_nx  = state_q;
        duty_nx   = duty_q;
        tgt_nx    = tgt_q;
        pduty_nx  = pduty_q;
        pdir_nx   = pdir_q;
        dwell_nx  = dwell_q;
        en_nx     = o_enable;
        pn_nx     = o_pn;
        dwell_inc = {1'b0, dwell_q} + (DWID+1)'(1);
        cmd_cl    = (i_cmd_duty > i_max_duty) ? i_max_duty : i_cmd_duty;
`ifdef HBRIDGE_CMD_WDOG_EN
        wd_cnt_nx = wd_cnt_q;
        wd_exp_nx = o_wdog_expired;
        wd_inc    = {1'b0, wd_cnt_q} + (DWID+1)'(1);
`endif

        if (i_stop) begin
            state_nx = IDLE;
            duty_nx  = '0;
            tgt_nx   = '0;
            pduty_nx = '0;
            pdir_nx  = o_pn;
            en_nx    = 1'b0;
`ifdef HBRIDGE_CMD_WDOG_EN
            wd_cnt_nx = '0;
`endif
        end else begin
            if (acc) begin
`ifdef HBRIDGE_CMD_WDOG_EN
                wd_cnt_nx = '0;
                wd_exp_nx = 1'b0;
`endif
                if (state_q == IDLE) begin
                    tgt_nx = cmd_cl;
                    if (cmd_cl != '0)
                        pdir_nx = i_cmd_dir;
                end else if (i_cmd_dir != o_pn) begin
                    pduty_nx = cmd_cl;
                    pdir_nx  = i_cmd_dir;
                    tgt_nx   = '0;
                    state_nx = DRAIN;
                end else begin
                    tgt_nx = cmd_cl;
                end
            end

            if (tick_c) begin
`ifdef HBRIDGE_CMD_WDOG_EN
                if (state_q == IDLE || i_wdog_periods == '0) begin
                    wd_cnt_nx = '0;
                end else if (!acc && !o_wdog_expired) begin
                    wd_cnt_nx = wd_inc[DWID-1:0];
                    if (wd_inc >= {1'b0, i_wdog_periods}) begin
                        wd_exp_nx = 1'b1;
                        tgt_nx    = '0;
                        pduty_nx  = '0;
                    end
                end
`endif
                case (state_nx)
                    IDLE: begin
                        if (tgt_nx != '0) begin
                            pn_nx    = pdir_nx;
                            en_nx    = 1'b1;
                            duty_nx  = ramp_step(duty_q, tgt_nx, i_step);
                            state_nx = RAMP;
                        end
                    end
                    RAMP: begin
                        duty_nx = ramp_step(duty_q, tgt_nx, i_step);
                        if (duty_nx == '0 && tgt_nx == '0) begin
                            en_nx    = 1'b0;
                            state_nx = IDLE;
                        end
                    end
                    DRAIN: begin
                        duty_nx = ramp_step(duty_q, '0, i_step);
                        if (duty_nx == '0) begin
                            en_nx    = 1'b0;
                            dwell_nx = '0;
                            state_nx = WAIT;
                        end
                    end
                    WAIT: begin
                        if (dwell_inc >= {1'b0, i_rev_wait}) begin
                            pn_nx    = pdir_nx;
                            en_nx    = 1'b1;
                            tgt_nx   = pduty_nx;
                            duty_nx  = ramp_step(duty_q, pduty_nx, i_step);
                            state_nx = RAMP;
                        end else begin
                            dwell_nx = dwell_inc[DWID-1:0];
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end

        at_nx   = (duty_nx == tgt_nx) && (state_nx == IDLE || state_nx == RAMP);
        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_hbridge_cmd_ramp.sv
// Directed bench for hbridge_cmd_ramp: ramp, reversal, clamp/jump, stop, async reset, optional watchdog.
module tb_hbridge_cmd_ramp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  period;
    logic [15:0] step;
    logic [15:0] max_duty;
    logic [7:0]  rev_wait;
    logic        stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_duty;
    logic        enable;
    logic        pn;
    logic [7:0]  hi_time;
    logic [7:0]  hi_frac;
    logic        tick;
    logic        at_target;
    logic        busy;
`ifdef HBRIDGE_CMD_WDOG_EN
    logic [7:0]  wdog;
    logic        wdog_exp;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hbridge_cmd_ramp #(.DWID(8), .FWID(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_period            (period),
        .i_step              (step),
        .i_max_duty          (max_duty),
        .i_rev_wait          (rev_wait),
        .i_stop              (stop),
        .i_cmd_valid         (cmd_valid),
        .o_cmd_ready         (cmd_ready),
        .i_cmd_dir           (cmd_dir),
        .i_cmd_duty          (cmd_duty),
        .o_enable            (enable),
        .o_pn                (pn),
        .o_hi_time           (hi_time),
        .o_hi_more_precision (hi_frac),
        .o_tick              (tick),
        .o_at_target         (at_target),
        .o_busy              (busy)
`ifdef HBRIDGE_CMD_WDOG_EN
        ,
        .i_wdog_periods      (wdog),
        .o_wdog_expired      (wdog_exp)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the negedge of the next o_tick cycle, bounded.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic send_cmd(input logic dir, input logic [15:0] duty);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_duty  = duty;
        check("cmd_ready_before_send", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic check_duty(input string tag, input logic [15:0] exp);
        check(tag, {16'd0, hi_time, hi_frac}, {16'd0, exp});
    endtask

    initial begin
        rst_n     = 1'b0;
        period    = 8'd100;
        step      = 16'h0100;
        max_duty  = 16'hFFFF;
        rev_wait  = 8'd3;
        stop      = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b1;
        cmd_duty  = '0;
`ifdef HBRIDGE_CMD_WDOG_EN
        wdog      = 8'd0;
`endif
        #12;
        check("rst_enable", 32'(enable), 32'd0);
        check("rst_pn", 32'(pn), 32'd1);
        check_duty("rst_duty", 16'h0000);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_at_target", 32'(at_target), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ramp to 0x28AB at +0x0100 per tick
        wait_tick();
        send_cmd(1'b1, 16'h28AB);
        check("ramp_at_target_pending", 32'(at_target), 32'd0);
        wait_tick();
        check("ramp_first_enable", 32'(enable), 32'd1);
        check("ramp_first_pn", 32'(pn), 32'd1);
        check_duty("ramp_first_duty", 16'h0100);
        check("ramp_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("tick_one_cycle", 32'(tick), 32'd0);
        for (int k = 2; k <= 40; k++) begin
            wait_tick();
            check_duty("ramp_step", 16'(k * 256));
        end
        check("ramp_not_yet_target", 32'(at_target), 32'd0);
        wait_tick();
        check_duty("ramp_final", 16'h28AB);
        check("ramp_at_target", 32'(at_target), 32'd1);

        // Reversal: drain 41 ticks, 3 ticks disabled, flip, ramp to 0x1400
        send_cmd(1'b0, 16'h1400);
        check("rev_ready_drop", 32'(cmd_ready), 32'd0);
        check("rev_not_at_target", 32'(at_target), 32'd0);
        wait_ticks(40);
        check_duty("rev_drain_40", 16'h00AB);
        check("rev_drain_en", 32'(enable), 32'd1);
        wait_tick();
        check_duty("rev_drain_zero", 16'h0000);
        check("rev_disable", 32'(enable), 32'd0);
        check("rev_pn_held", 32'(pn), 32'd1);
        wait_tick();
        check("rev_dwell_2", 32'(enable), 32'd0);
        wait_tick();
        check("rev_dwell_3", 32'(enable), 32'd0);
        check("rev_ready_wait", 32'(cmd_ready), 32'd0);
        wait_tick();
        check("rev_reenable", 32'(enable), 32'd1);
        check("rev_pn_flip", 32'(pn), 32'd0);
        check_duty("rev_up_first", 16'h0100);
        wait_ticks(18);
        check_duty("rev_up_19", 16'h1300);
        wait_tick();
        check_duty("rev_up_final", 16'h1400);
        check("rev_at_target", 32'(at_target), 32'd1);
        check("rev_ready_back", 32'(cmd_ready), 32'd1);

        // Clamp to 0x5000 and jump in one tick with step 0
        period   = 8'd10;
        max_duty = 16'h5000;
        step     = 16'h0000;
        send_cmd(1'b0, 16'h6400);
        wait_tick();
        check_duty("clamp_jump", 16'h5000);
        check("clamp_at_target", 32'(at_target), 32'd1);

        // Stop mid-ramp together with a valid command
        step = 16'h0100;
        send_cmd(1'b0, 16'h1000);
        wait_ticks(3);
        check_duty("stop_pre", 16'h4D00);
        stop      = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_duty  = 16'h3000;
        #1;
        check("stop_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        stop      = 1'b0;
        cmd_valid = 1'b0;
        check("stop_enable", 32'(enable), 32'd0);
        check_duty("stop_duty", 16'h0000);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_at_target", 32'(at_target), 32'd1);
        wait_tick();
        check("stop_cmd_dropped_en", 32'(enable), 32'd0);
        check_duty("stop_cmd_dropped_duty", 16'h0000);

        // Async reset during DRAIN
        send_cmd(1'b1, 16'h0800);
        wait_tick();
        check("idle_pn_flip", 32'(pn), 32'd1);
        check("idle_enable", 32'(enable), 32'd1);
        wait_ticks(7);
        check_duty("pre_drain", 16'h0800);
        send_cmd(1'b0, 16'h0400);
        wait_ticks(2);
        check_duty("drain_mid", 16'h0600);
        check("drain_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_enable", 32'(enable), 32'd0);
        check("arst_pn", 32'(pn), 32'd1);
        check_duty("arst_duty", 16'h0000);
        check("arst_tick", 32'(tick), 32'd0);
        check("arst_at_target", 32'(at_target), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_enable", 32'(enable), 32'd0);

`ifdef HBRIDGE_CMD_WDOG_EN
        // Watchdog: armed once at 0x2000, expires after 5 silent ticks
        wait_tick();
        send_cmd(1'b1, 16'h2000);
        wait_ticks(32);
        check_duty("wd_reach", 16'h2000);
        wdog = 8'd5;
        wait_ticks(4);
        check("wd_not_yet", 32'(wdog_exp), 32'd0);
        check_duty("wd_hold", 16'h2000);
        wait_tick();
        check("wd_expired", 32'(wdog_exp), 32'd1);
        check_duty("wd_ramp_down", 16'h1F00);
        wait_ticks(31);
        check_duty("wd_zero", 16'h0000);
        check("wd_disable", 32'(enable), 32'd0);
        check("wd_sticky", 32'(wdog_exp), 32'd1);
        wait_tick();
        send_cmd(1'b1, 16'h0100);
        check("wd_cleared", 32'(wdog_exp), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
